// File: rtl/gb_apu_pkg.sv
// Shared widths, pan bit positions and gain helper for the Game Boy APU mixer.
package gb_apu_pkg;

  localparam int unsigned LEVEL_W    = 4;
  localparam int unsigned SUM_W      = 6;
  localparam int unsigned MIX_W      = 9;
  localparam int unsigned VOL_W      = 3;
  localparam int unsigned PAN_W      = 8;
  localparam int unsigned NUM_CH     = 4;
  localparam int unsigned ACC_W      = MIX_W + 1;
  localparam int unsigned CNT_W      = 16;
  localparam int unsigned PROD_W     = SUM_W + VOL_W + 1;
  localparam int unsigned PAN_L_BASE = 4;
  localparam int unsigned PAN_R_BASE = 0;

  typedef logic [MIX_W-1:0]   mix_t;
  typedef logic [LEVEL_W-1:0] level_t;
  typedef logic [SUM_W-1:0]   sum_t;
  typedef logic [VOL_W-1:0]   vol_t;

  // Master volume gain is (vol+1); 60 * 8 = 480 always fits in a mix_t.
  function automatic mix_t apply_gain(sum_t s, vol_t vol);
    logic [VOL_W:0] g;
    g = (VOL_W+1)'(vol) + (VOL_W+1)'(1);
    return MIX_W'(PROD_W'(s) * PROD_W'(g));
  endfunction

endpackage

// File: rtl/gb_apu_mixer_if.sv
// Channel/register inputs and mixed/sampled/PWM outputs of the APU mixer.
interface gb_apu_mixer_if;
  import gb_apu_pkg::*;

  logic             apu_enable;
  level_t           ch1_level, ch2_level, ch3_level, ch4_level;
  logic             ch1_enable, ch2_enable, ch3_enable, ch4_enable;
  logic [PAN_W-1:0] nr51_pan;
  vol_t             nr50_left_vol, nr50_right_vol;
  mix_t             mix_left, mix_right;
  logic             sample_strobe;
  mix_t             left_sample, right_sample;
  logic             left_pwm, right_pwm;

  modport master (
    output apu_enable,
    output ch1_level, ch2_level, ch3_level, ch4_level,
    output ch1_enable, ch2_enable, ch3_enable, ch4_enable,
    output nr51_pan, nr50_left_vol, nr50_right_vol,
    input  mix_left, mix_right, sample_strobe,
    input  left_sample, right_sample, left_pwm, right_pwm
  );

  modport slave (
    input  apu_enable,
    input  ch1_level, ch2_level, ch3_level, ch4_level,
    input  ch1_enable, ch2_enable, ch3_enable, ch4_enable,
    input  nr51_pan, nr50_left_vol, nr50_right_vol,
    output mix_left, mix_right, sample_strobe,
    output left_sample, right_sample, left_pwm, right_pwm
  );

endinterface

// File: rtl/gb_sigma_delta_dac.sv
// First-order sigma-delta modulator: 9-bit sample in, 1-bit density-coded stream out.
module gb_sigma_delta_dac
  import gb_apu_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  mix_t sample,
  output logic pwm
);

  logic [ACC_W-1:0] acc_q, acc_d;

  // Carry out of the 9-bit accumulator is the output bit; it is dropped on feedback.
  always_comb begin
    acc_d = {1'b0, acc_q[ACC_W-2:0]} + ACC_W'(sample);
  end

  always_ff @(posedge clk) begin
    if (!reset || !enable) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign pwm = acc_q[ACC_W-1];

endmodule

// File: rtl/gb_apu_mixer.sv
// APU output mixer: pan/enable gating, master volume, sample strobe and per-side sigma-delta DAC.
module gb_apu_mixer
  import gb_apu_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV = 95
) (
  input  logic           clk,
  input  logic           reset,
  gb_apu_mixer_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);

  level_t            lvl [NUM_CH];
  logic [NUM_CH-1:0] ch_en;
  logic              active;

  sum_t             sum_l_q, sum_l_d, sum_r_q, sum_r_d;
  mix_t             mix_l_q, mix_l_d, mix_r_q, mix_r_d;
  mix_t             smp_l_q, smp_l_d, smp_r_q, smp_r_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             strobe_q, strobe_d;
  logic             wrap;

  assign lvl[0] = bus.ch1_level;
  assign lvl[1] = bus.ch2_level;
  assign lvl[2] = bus.ch3_level;
  assign lvl[3] = bus.ch4_level;
  assign ch_en  = {bus.ch4_enable, bus.ch3_enable, bus.ch2_enable, bus.ch1_enable};
  assign active = reset && bus.apu_enable;
  assign wrap   = (cnt_q == CNT_LAST);

  // Stage 1 sums and stage 2 gain; NR50/NR51 feed their stage directly.
  always_comb begin
    sum_l_d = '0;
    sum_r_d = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      if (ch_en[n] && bus.nr51_pan[PAN_L_BASE + n]) sum_l_d = sum_l_d + SUM_W'(lvl[n]);
      if (ch_en[n] && bus.nr51_pan[PAN_R_BASE + n]) sum_r_d = sum_r_d + SUM_W'(lvl[n]);
    end
    mix_l_d = apply_gain(sum_l_q, bus.nr50_left_vol);
    mix_r_d = apply_gain(sum_r_q, bus.nr50_right_vol);
  end

  // Sample counter; the held samples capture the mix on the same edge the strobe rises.
  always_comb begin
    cnt_d    = wrap ? '0 : cnt_q + CNT_W'(1);
    strobe_d = wrap;
    smp_l_d  = wrap ? mix_l_q : smp_l_q;
    smp_r_d  = wrap ? mix_r_q : smp_r_q;
  end

  always_ff @(posedge clk) begin
    if (!active) begin
      sum_l_q  <= '0;
      sum_r_q  <= '0;
      mix_l_q  <= '0;
      mix_r_q  <= '0;
      smp_l_q  <= '0;
      smp_r_q  <= '0;
      cnt_q    <= '0;
      strobe_q <= 1'b0;
    end else begin
      sum_l_q  <= sum_l_d;
      sum_r_q  <= sum_r_d;
      mix_l_q  <= mix_l_d;
      mix_r_q  <= mix_r_d;
      smp_l_q  <= smp_l_d;
      smp_r_q  <= smp_r_d;
      cnt_q    <= cnt_d;
      strobe_q <= strobe_d;
    end
  end

  assign bus.mix_left      = mix_l_q;
  assign bus.mix_right     = mix_r_q;
  assign bus.left_sample   = smp_l_q;
  assign bus.right_sample  = smp_r_q;
  assign bus.sample_strobe = strobe_q;

  gb_sigma_delta_dac u_dac_left (
    .clk    (clk),
    .reset  (reset),
    .enable (bus.apu_enable),
    .sample (smp_l_q),
    .pwm    (bus.left_pwm)
  );

  gb_sigma_delta_dac u_dac_right (
    .clk    (clk),
    .reset  (reset),
    .enable (bus.apu_enable),
    .sample (smp_r_q),
    .pwm    (bus.right_pwm)
  );

endmodule
